// File: rtl/wave_osc.sv
// Phase-accumulator oscillator producing saw/square/triangle/silence samples with
// wrap-synchronised config updates. Optional hard sync input: WAVE_OSC_HARD_SYNC_EN.
module wave_osc #(
    parameter int BIT_WIDTH   = 16,
    parameter int PHASE_WIDTH = 24
) (
    input  logic                   clk_audio,
    input  logic                   rst_audio,
    input  logic                   sample_tick,
    input  logic [PHASE_WIDTH-1:0] freq_word,
    input  logic [1:0]             wave_sel,
    input  logic                   cfg_load,
`ifdef WAVE_OSC_HARD_SYNC_EN
    input  logic                   sync_in,
`endif
    output logic                   cfg_pending,
    output logic [BIT_WIDTH-1:0]   level,
    output logic                   level_valid
);

    generate
        if (PHASE_WIDTH < BIT_WIDTH) begin : g_bad_phase_width
            $error("wave_osc: PHASE_WIDTH must be >= BIT_WIDTH");
        end
        if (BIT_WIDTH < 4) begin : g_bad_bit_width
            $error("wave_osc: BIT_WIDTH must be >= 4");
        end
    endgenerate

    localparam logic [1:0] WAVE_SAW    = 2'd0;
    localparam logic [1:0] WAVE_SQUARE = 2'd1;
    localparam logic [1:0] WAVE_TRI    = 2'd2;
    localparam logic [1:0] WAVE_SILENT = 2'd3;

    localparam logic [BIT_WIDTH-1:0] HALF     = {1'b1, {(BIT_WIDTH-1){1'b0}}};
    localparam logic [BIT_WIDTH-1:0] POS_PEAK = {1'b0, {(BIT_WIDTH-1){1'b1}}};
    localparam logic [BIT_WIDTH-1:0] NEG_PEAK = {1'b1, {(BIT_WIDTH-2){1'b0}}, 1'b1};

    logic [PHASE_WIDTH-1:0] phase;
    logic [PHASE_WIDTH-1:0] active_freq;
    logic [PHASE_WIDTH-1:0] pending_freq;
    logic [1:0]             active_wave;
    logic [1:0]             pending_wave;

    logic [PHASE_WIDTH:0]   sum;
    logic [PHASE_WIDTH-1:0] next_phase;
    logic                   wrap;
    logic [BIT_WIDTH-1:0]   t;
    logic [BIT_WIDTH-1:0]   u;
    logic [BIT_WIDTH-1:0]   wave_level;
    logic                   apply;

    assign sum = {1'b0, phase} + {1'b0, active_freq};

    always_comb begin
        next_phase = sum[PHASE_WIDTH-1:0];
        wrap       = sum[PHASE_WIDTH];
`ifdef WAVE_OSC_HARD_SYNC_EN
        // Hard sync restarts the cycle and counts as a wrap so pending config lands.
        if (sync_in) begin
            next_phase = '0;
            wrap       = 1'b1;
        end
`endif
    end

    assign t = next_phase[PHASE_WIDTH-1 -: BIT_WIDTH];
    assign u = t[BIT_WIDTH-1] ? ~t : t;

    always_comb begin
        wave_level = '0;
        case (active_wave)
            WAVE_SAW:    wave_level = t ^ HALF;
            WAVE_SQUARE: wave_level = t[BIT_WIDTH-1] ? NEG_PEAK : POS_PEAK;
            WAVE_TRI:    wave_level = {u[BIT_WIDTH-2:0], 1'b0} ^ HALF;
            WAVE_SILENT: wave_level = '0;
            default:     wave_level = '0;
        endcase
    end

    // A stopped oscillator (freq 0) never wraps, so it accepts config on any tick.
    assign apply = sample_tick && cfg_pending && (wrap || (active_freq == '0));

    always_ff @(posedge clk_audio) begin
        if (rst_audio) begin
            phase        <= '0;
            level        <= '0;
            level_valid  <= 1'b0;
            active_freq  <= '0;
            pending_freq <= '0;
            active_wave  <= WAVE_SILENT;
            pending_wave <= WAVE_SILENT;
            cfg_pending  <= 1'b0;
        end else begin
            level_valid <= sample_tick;
            if (sample_tick) begin
                phase <= next_phase;
                level <= wave_level;
            end
            if (apply) begin
                active_freq <= pending_freq;
                active_wave <= pending_wave;
            end
            if (cfg_load) begin
                pending_freq <= freq_word;
                pending_wave <= wave_sel;
                cfg_pending  <= 1'b1;
            end else if (apply) begin
                cfg_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wave_osc.sv
// Self-checking bench for wave_osc (16-bit samples, 16-bit phase): directed
// scenarios followed by random traffic, all checked against an arithmetic model.
module tb_wave_osc;

    localparam int BW = 16;
    localparam int PW = 16;
    localparam int MOD = 1 << PW;
    localparam int M = 1 << (BW - 1);

    logic          clk_audio = 1'b0;
    logic          rst_audio;
    logic          sample_tick;
    logic [PW-1:0] freq_word;
    logic [1:0]    wave_sel;
    logic          cfg_load;
    logic          sync_in;
    logic          cfg_pending;
    logic [BW-1:0] level;
    logic          level_valid;

    int total = 0;
    int bad = 0;

    // Model state as plain integers
    int m_phase, m_afreq, m_awave, m_pfreq, m_pwave, m_pend, m_level, m_vld;

    wave_osc #(.BIT_WIDTH(BW), .PHASE_WIDTH(PW)) dut (
        .clk_audio   (clk_audio),
        .rst_audio   (rst_audio),
        .sample_tick (sample_tick),
        .freq_word   (freq_word),
        .wave_sel    (wave_sel),
        .cfg_load    (cfg_load),
`ifdef WAVE_OSC_HARD_SYNC_EN
        .sync_in     (sync_in),
`endif
        .cfg_pending (cfg_pending),
        .level       (level),
        .level_valid (level_valid)
    );

    always #5 clk_audio = ~clk_audio;

    // Sample shape as a function of the top phase bits, unsigned 0..2^BW-1.
    function automatic int shape(input int w, input int t);
        int v;
        case (w)
            0: return (t + M) % (2 * M);
            1: return (t < M) ? (M - 1) : (2 * M - (M - 1));
            2: begin
                v = (t < M) ? 2 * t : 2 * (2 * M - 1 - t);
                return (v + M) % (2 * M);
            end
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit tk, input bit ld,
                              input int fw, input int ws, input bit sy);
        int sum, np, pf, pw;
        bit wrp, app;
        if (r) begin
            m_phase = 0; m_level = 0; m_vld = 0; m_afreq = 0; m_pfreq = 0;
            m_awave = 3; m_pwave = 3; m_pend = 0;
            return;
        end
        m_vld = tk;
        pf = m_pfreq; pw = m_pwave;
        if (tk) begin
            sum = m_phase + m_afreq;
            wrp = (sum >= MOD);
            np  = sum % MOD;
`ifdef WAVE_OSC_HARD_SYNC_EN
            if (sy) begin np = 0; wrp = 1; end
`endif
            m_level = shape(m_awave, np / (1 << (PW - BW)));
            app = (m_pend != 0) && (wrp || m_afreq == 0);
            if (app) begin m_afreq = pf; m_awave = pw; m_pend = 0; end
            m_phase = np;
        end
        if (ld) begin m_pfreq = fw; m_pwave = ws; m_pend = 1; end
    endtask

    // One clock: drive, update model, check all outputs 1 time unit after the edge.
    task automatic cyc(input bit r, input bit tk, input bit ld,
                       input int fw, input int ws, input bit sy);
        logic [BW-1:0] el;
        rst_audio = r; sample_tick = tk; cfg_load = ld;
        freq_word = fw[PW-1:0]; wave_sel = ws[1:0]; sync_in = sy;
        @(posedge clk_audio);
        model_step(r, tk, ld, fw, ws, sy);
        #1;
        el = m_level[BW-1:0];
        chk("level", level, el);
        chk("level_valid", level_valid, m_vld[0]);
        chk("cfg_pending", cfg_pending, m_pend[0]);
    endtask

    task automatic tick(); cyc(0, 1, 0, 0, 0, 0); endtask
    task automatic idle(); cyc(0, 0, 0, 0, 0, 0); endtask

    initial begin
        rst_audio = 1; sample_tick = 0; cfg_load = 0; freq_word = '0; wave_sel = '0; sync_in = 0;
        // Reset cycle also carries a tick and a load, both must be ignored
        cyc(1, 1, 1, 16'h1234, 1, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("reset_level", level, 16'h0000);
        chk("reset_pending", cfg_pending, 1'b0);

        // Start-up saw
        cyc(0, 0, 1, 16'h1000, 0, 0);
        chk("load_pending", cfg_pending, 1'b1);
        tick();
        chk("tick1_pending", cfg_pending, 1'b0);
        chk("tick1_level", level, 16'h0000);
        idle();
        chk("valid_drop", level_valid, 1'b0);
        tick();
        chk("tick2_level", level, 16'h9000);
        for (int i = 0; i < 14; i++) begin tick(); if (i % 3 == 0) idle(); end
        chk("saw_top", level, 16'h7000);
        tick();
        chk("saw_wrap", level, 16'h8000);

        // Mid-period load waits for wrap
        for (int i = 0; i < 3; i++) tick();
        cyc(0, 0, 1, 16'h2000, 1, 0);
        for (int i = 0; i < 12; i++) tick();
        chk("held_pending", cfg_pending, 1'b1);
        tick();
        chk("wrap_apply", cfg_pending, 1'b0);
        tick();
        chk("square_pos", level, 16'h7FFF);

        // Triangle, phase at 0x2000 moving by 0x2000 -> 7 ticks to wrap
        cyc(0, 0, 1, 16'h4000, 2, 0);
        for (int i = 0; i < 7; i++) tick();
        tick(); chk("tri_q1", level, 16'h0000);
        tick(); chk("tri_q2", level, 16'h7FFE);
        tick(); chk("tri_q3", level, 16'hFFFE);
        tick(); chk("tri_q4", level, 16'h8000);

        // Load coinciding with an applying wrap tick
        cyc(0, 0, 1, 16'h1000, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        cyc(0, 1, 1, 16'h3000, 1, 0);
        chk("simul_pending", cfg_pending, 1'b1);
        tick();
        chk("simul_old_applied", level, 16'h9000);

        // Reset mid-run with a tick and load in the same cycle
        cyc(1, 1, 1, 16'h0800, 0, 0);
        chk("midrst_level", level, 16'h0000);
        chk("midrst_valid", level_valid, 1'b0);
        chk("midrst_pending", cfg_pending, 1'b0);

`ifdef WAVE_OSC_HARD_SYNC_EN
        cyc(0, 0, 1, 16'h1000, 0, 0);
        tick();
        for (int i = 0; i < 5; i++) tick();
        cyc(0, 1, 0, 0, 0, 1);
        chk("sync_level", level, 16'h8000);
        tick();
        chk("sync_next", level, 16'h9000);
`endif

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            int fw;
            fw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) * 16'h1000 : $urandom_range(0, MOD - 1);
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 9) == 0),
                fw, $urandom_range(0, 3),
                ($urandom_range(0, 19) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
